// File: rtl/ram_march_tester_if.sv
// rtl/ram_march_tester_if.sv - RAM bank bus between the march tester and the cells
//
// Purpose : groups the shared RAM bank signals into one bundle.
// Signals : r_w      - 0 = write, 1 = read
//           addr_sel - one-hot cell select, all-zero when idle
//           d_in     - write data towards the RAM
//           d_out    - read data from the RAM (RAM updates it on negedge)
// Modports: master - the tester (drives r_w/addr_sel/d_in, reads d_out)
//           slave  - the RAM bank
interface ram_march_tester_if #(
    parameter int DEPTH = 4,
    parameter int W     = 4
);
    logic             r_w;
    logic [DEPTH-1:0] addr_sel;
    logic [W-1:0]     d_in;
    logic [W-1:0]     d_out;

    modport master (
        output r_w,
        output addr_sel,
        output d_in,
        input  d_out
    );

    modport slave (
        input  r_w,
        input  addr_sel,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/ram_march_tester.sv
// rtl/ram_march_tester.sv - 4-phase march test initiator for a bank of 1xW RAM cells
//
// Purpose : on an accepted start, writes pat to every cell, reads it back,
//           writes ~pat to every cell, reads it back, and reports the result.
// Ports   : clk         - clock, all state changes on posedge
//           rst_n       - asynchronous active-low reset
//           start_i     - 1-cycle request, sampled only in IDLE or DONE
//           pat_i       - test pattern, captured on accepted start
//           ram         - RAM bank bus (master side)
//           busy_o      - high while a test phase is active
//           done_o      - high from completion until next accepted start
//           pass_o      - valid with done_o, 1 = no mismatches
//           err_cnt_o   - saturating mismatch count
//           fail_addr_o - address of the first mismatch, 0 if none
module ram_march_tester #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 4,
    parameter int EW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [W-1:0]         pat_i,
    ram_march_tester_if.master   ram,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [EW-1:0]        err_cnt_o,
    output logic [AW-1:0]        fail_addr_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR0  = 3'd1;
    localparam logic [2:0] S_RD0  = 3'd2;
    localparam logic [2:0] S_WR1  = 3'd3;
    localparam logic [2:0] S_RD1  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [DEPTH-1:0] SEL_ONE   = DEPTH'(1);

    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [W-1:0]  pat_q,       pat_d;
    logic [EW-1:0] err_q,       err_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic          pass_q,      pass_d;
    logic          done_q,      done_d;

    logic          is_wr;
    logic          is_rd;
    logic          inv_phase;
    logic          last_addr;
    logic          mismatch;
    logic [W-1:0]  exp_data;

    assign is_wr     = (state_q == S_WR0) || (state_q == S_WR1);
    assign is_rd     = (state_q == S_RD0) || (state_q == S_RD1);
    assign inv_phase = (state_q == S_WR1) || (state_q == S_RD1);
    assign last_addr = (addr_q == LAST_ADDR);
    // The same value serves as write data and as read-back expectation.
    assign exp_data  = inv_phase ? ~pat_q : pat_q;

    // Equality drives the "match" branch only when it is definitely true, so an
    // unknown D_OUT bit falls through to the mismatch branch in simulation.
    always_comb begin
        mismatch = 1'b0;
        if (is_rd) begin
            if (ram.d_out == exp_data) begin
                mismatch = 1'b0;
            end else begin
                mismatch = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        pass_d      = pass_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_WR0;
                    addr_d      = '0;
                    pat_d       = pat_i;
                    err_d       = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                    done_d      = 1'b0;
                end
            end
            S_WR0, S_RD0, S_WR1, S_RD1: begin
                addr_d = last_addr ? '0 : addr_q + AW'(1);
                if (mismatch) begin
                    // The counter saturates, so a zero count still means
                    // "no mismatch seen yet" and marks the first failure.
                    if (err_q == '0) begin
                        fail_addr_d = addr_q;
                    end
                    if (!(&err_q)) begin
                        err_d = err_q + EW'(1);
                    end
                end
                if (last_addr) begin
                    case (state_q)
                        S_WR0:   state_d = S_RD0;
                        S_RD0:   state_d = S_WR1;
                        S_WR1:   state_d = S_RD1;
                        default: begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            // Uses the count including this cycle's compare.
                            pass_d  = (err_d == '0);
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pat_q       <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    // RAM strobes decode directly from registered state so that an
    // asynchronous reset parks the bus at once (read, no cell selected).
    assign ram.r_w      = ~is_wr;
    assign ram.addr_sel = (is_wr || is_rd) ? (SEL_ONE << addr_q) : '0;
    assign ram.d_in     = is_wr ? exp_data : '0;

    assign busy_o      = is_wr || is_rd;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
    assign fail_addr_o = fail_addr_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// tb/tb_ram_march_tester.sv - self-checking bench for ram_march_tester with a faultable RAM model
module tb_ram_march_tester;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int W     = 4;
    localparam int EW    = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  pat   = '0;
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] fail_addr;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] mem   [DEPTH];
    logic [W-1:0] and_m [DEPTH];
    logic [W-1:0] or_m  [DEPTH];
    bit           xcell [DEPTH];
    logic [W-1:0] xval;
    int           bad_writes = 0;

    ram_march_tester_if #(.DEPTH(DEPTH), .W(W)) bus ();

    ram_march_tester #(.DEPTH(DEPTH), .AW(AW), .W(W), .EW(EW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .pat_i       (pat),
        .ram         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_cnt_o   (err_cnt),
        .fail_addr_o (fail_addr)
    );

    always #5 clk = ~clk;

    // RAM bank: latches writes on posedge, drives reads at negedge with faults.
    always @(posedge clk) begin
        if (rst_n && bus.r_w === 1'b0) begin
            if ($countones(bus.addr_sel) != 1) bad_writes <= bad_writes + 1;
            else for (int i = 0; i < DEPTH; i++) if (bus.addr_sel[i]) mem[i] <= bus.d_in;
        end
    end

    always @(negedge clk) begin
        if (bus.r_w === 1'b1 && $countones(bus.addr_sel) == 1) begin
            for (int i = 0; i < DEPTH; i++)
                if (bus.addr_sel[i])
                    bus.d_out <= xcell[i] ? xval : ((mem[i] & and_m[i]) | or_m[i]);
        end else begin
            bus.d_out <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            and_m[i] = '1;
            or_m[i]  = '0;
            xcell[i] = 1'b0;
        end
    endtask

    // Reference: what each read returns given the faults, over both phases.
    task automatic model(input logic [W-1:0] p, output int cnt, output int first);
        logic [W-1:0] v, r;
        cnt = 0;
        first = 0;
        for (int ph = 0; ph < 2; ph++) begin
            v = (ph == 0) ? p : ~p;
            for (int a = 0; a < DEPTH; a++) begin
                r = xcell[a] ? xval : ((v & and_m[a]) | or_m[a]);
                if (r !== v) begin
                    if (cnt == 0) first = a;
                    cnt++;
                end
            end
        end
    endtask

    task automatic run_test(input logic [W-1:0] p, input int s1, input int s2, input string tag);
        int cnt, first, busy_cycles, exp_err;
        bit fin;
        model(p, cnt, first);
        exp_err = (cnt > (2 ** EW) - 1) ? (2 ** EW) - 1 : cnt;
        @(negedge clk);
        pat = p;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pat = W'($urandom);
        check({tag, " done_cleared"}, 32'(done), 32'd0);
        busy_cycles = 0;
        fin = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                fin = 1'b1;
            end else begin
                if (c == s1 || c == s2) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        check({tag, " completed"}, 32'(fin), 32'd1);
        check({tag, " busy_len"}, 32'(busy_cycles), 32'(4 * DEPTH));
        check({tag, " pass"}, 32'(pass), 32'(cnt == 0));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({tag, " fail_addr"}, 32'(fail_addr), 32'(first));
        check({tag, " idle_bus"}, {31'd0, bus.r_w} | 32'(bus.addr_sel) << 1, 32'd1);
        check({tag, " no_bad_write"}, 32'(bad_writes), 32'd0);
    endtask

    initial begin
        xval = 'x;
        clear_faults();
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        check("reset err", 32'(err_cnt), 32'd0);
        check("reset fail_addr", 32'(fail_addr), 32'd0);
        check("reset bus", {27'd0, bus.d_in, bus.r_w} | 32'(bus.addr_sel) << 5, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_test(4'hA, 0, 0, "t1_healthy");

        and_m[2] = 4'hE;
        run_test(4'h5, 0, 0, "t2_stuck0");
        clear_faults();

        xcell[1] = 1'b1;
        run_test(4'h0, 0, 0, "t3_xcell");
        clear_faults();

        run_test(4'h3, 3, 7, "t4_start_ignored");

        // Reset in the middle of RD0 with one mismatch already recorded.
        and_m[0] = 4'h0;
        @(negedge clk);
        pat = 4'hF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t5 pre_reset err", 32'(err_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async busy", 32'(busy), 32'd0);
        check("t5 async err", 32'(err_cnt), 32'd0);
        check("t5 async bus", {27'd0, bus.d_in, bus.r_w} | 32'(bus.addr_sel) << 5, 32'd1);
        check("t5 async done_pass", {30'd0, done, pass}, 32'd0);
        clear_faults();
        @(negedge clk);
        rst_n = 1'b1;
        run_test(4'h9, 0, 0, "t5_after_reset");

        for (int i = 0; i < DEPTH; i++) or_m[i] = 4'hF;
        run_test(4'h0, 0, 0, "t6_saturate");
        clear_faults();
        run_test(4'h6, 0, 0, "t6_restart");

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                and_m[i] = ($urandom_range(3) == 0) ? W'($urandom) : '1;
                or_m[i]  = ($urandom_range(3) == 0) ? W'($urandom) : '0;
                xcell[i] = ($urandom_range(7) == 0);
            end
            run_test(W'($urandom), int'($urandom_range(2, 15)), int'($urandom_range(2, 15)),
                     $sformatf("rand%0d", it));
        end
        clear_faults();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
